adc_stream_reader: RTL

Digital reader for the SAR ADC sample interface. It captures each 8-bit conversion result when the converter's asynchronous `done` strobe rises, buffers results in a small FIFO, and streams them to an external host over a mode-0 SPI responder port. It sits beside the ADC macro in the tile, with `adc_done`/`adc_data` wired to the converter's done and sampled-data outputs and the SPI pins mapped to `uio`.

---
 rtl/adc_stream_reader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/adc_stream_reader.sv
// SAR ADC sample reader: captures conversions into a small FIFO
// and streams them to a host through a mode-0 SPI responder.
module adc_stream_reader #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          adc_done,
  input  logic [DW-1:0] adc_data,
  input  logic          spi_csn,
  input  logic          spi_sclk,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic [2:0]    fifo_count,
  output logic          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  // [0],[1] synchronize; [2] is the delayed copy for edge detect
  logic [2:0] done_q;
  logic [2:0] csn_q;
  logic [2:0] sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 3'b000;
      csn_q  <= 3'b111;
      sclk_q <= 3'b000;
    end else begin
      done_q <= {done_q[1:0], adc_done};
      csn_q  <= {csn_q[1:0], spi_csn};
      sclk_q <= {sclk_q[1:0], spi_sclk};
    end
  end

  logic done_rise;
  logic csn_fall;
  logic csn_rise;
  logic sclk_fall;

  assign done_rise = done_q[1] & ~done_q[2];
  assign csn_fall  = ~csn_q[1] & csn_q[2];
  assign csn_rise  = csn_q[1] & ~csn_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ~csn_q[1];

  state_e          state_q;
  logic [15:0]     shreg_q;
  logic [3:0]      bitcnt_q;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;

  logic            load;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push_req;
  logic            push;
  logic            drop;
  logic [15:0]     frame;

  assign load     = (state_q == IDLE) & csn_fall;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign pop      = load & ~empty & en;
  assign push_req = done_rise & en;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  assign frame = {pop, overflow_q,
                  3'(count_q - CW'(pop)), 3'b000,
                  pop ? mem_q[rptr_q] : DW'(0)};

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (!en) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      unique case (1'b1)
        push & ~pop: count_d = count_q + CW'(1);
        pop & ~push: count_d = count_q - CW'(1);
        default:     count_d = count_q;
      endcase
      overflow_d = (overflow_q & ~load) | drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (push) mem_q[wptr_q] <= adc_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      spi_miso <= 1'b0;
    end else if (csn_rise) begin
      state_q  <= IDLE;
      spi_miso <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            state_q  <= LOAD;
            shreg_q  <= frame;
            spi_miso <= frame[15];
          end
        end
        LOAD: begin
          state_q  <= SHIFT;
          bitcnt_q <= '0;
        end
        SHIFT: begin
          if (sclk_fall) begin
            if (bitcnt_q == 4'd15) begin
              state_q  <= DONE;
              spi_miso <= 1'b0;
            end else begin
              shreg_q  <= {shreg_q[14:0], 1'b0};
              spi_miso <= shreg_q[14];
              bitcnt_q <= bitcnt_q + 4'd1;
            end
          end
        end
        DONE: spi_miso <= 1'b0;
        default: begin
          state_q  <= IDLE;
          spi_miso <= 1'b0;
        end
      endcase
    end
  end

  assign spi_miso_oe = ~csn_q[1];
  assign fifo_count  = 3'(count_q);
  assign overflow    = overflow_q;

endmodule
